// File: rtl/l1_repl_ctrl.sv
// True-LRU replacement controller for an N-way L1 data cache.
// Holds per-set rank/valid state and serialises HIT / MISS / INVAL requests.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | ready for a request; req_ready high
// S_LOOKUP | pick the victim (MISS) or detect a hit on an invalid way (HIT)
// S_UPDATE | rewrite the rank/valid entries of the latched set
// S_RESP   | response held until rsp_ready
module l1_repl_ctrl #(
   parameter int NUM_SETS = 16,
   parameter int WAYS     = 8,
   localparam int SET_W   = $clog2(NUM_SETS),
   localparam int WAY_W   = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [SET_W-1:0] req_set,
   input  logic [WAY_W-1:0] req_way,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WAY_W-1:0] rsp_way,
   output logic             rsp_evict,
   output logic             rsp_err
);

   localparam logic [1:0] OP_HIT   = 2'b00;
   localparam logic [1:0] OP_MISS  = 2'b01;
   localparam logic [1:0] OP_INVAL = 2'b10;
   localparam logic [1:0] OP_NOP   = 2'b11;
   localparam logic [WAY_W-1:0] LRU_RANK = WAY_W'(WAYS - 1);

   typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_RESP} state_t;

   state_t state;

   logic [NUM_SETS-1:0][WAYS-1:0][WAY_W-1:0] rank;
   logic [NUM_SETS-1:0][WAYS-1:0]            valid;

   logic [1:0]       op_q;
   logic [SET_W-1:0] set_q;
   logic [WAY_W-1:0] way_q;
   logic [WAY_W-1:0] tgt_q;
   logic             evict_q;
   logic             err_q;

   logic [WAY_W-1:0] victim;
   logic             found_free;
   logic [WAY_W-1:0] old_rank;
   logic             promote;
   logic             demote;

   // Free ways are preferred (lowest index first); otherwise evict the LRU way.
   always_comb begin
      victim     = '0;
      found_free = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found_free && !valid[set_q][w]) begin
            victim     = WAY_W'(w);
            found_free = 1'b1;
         end
      end
      if (!found_free) begin
         for (int w = 0; w < WAYS; w++) begin
            if (rank[set_q][w] == LRU_RANK) victim = WAY_W'(w);
         end
      end
   end

   assign old_rank = rank[set_q][tgt_q];
   assign promote  = (op_q == OP_MISS) || ((op_q == OP_HIT) && !err_q);
   assign demote   = (op_q == OP_INVAL);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_way   <= '0;
         rsp_evict <= 1'b0;
         rsp_err   <= 1'b0;
         op_q      <= OP_NOP;
         set_q     <= '0;
         way_q     <= '0;
         tgt_q     <= '0;
         evict_q   <= 1'b0;
         err_q     <= 1'b0;
         valid     <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               rank[s][w] <= WAY_W'(w);
            end
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q      <= req_op;
                  set_q     <= req_set;
                  way_q     <= req_way;
                  req_ready <= 1'b0;
                  state     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               tgt_q   <= (op_q == OP_MISS) ? victim : way_q;
               evict_q <= (op_q == OP_MISS) && valid[set_q][victim];
               err_q   <= (op_q == OP_HIT) && !valid[set_q][way_q];
               state   <= S_UPDATE;
            end
            S_UPDATE: begin
               // Ranks stay a permutation: promote shifts the younger ways down,
               // demote shifts the older ways up.
               for (int w = 0; w < WAYS; w++) begin
                  if (promote) begin
                     if (WAY_W'(w) == tgt_q)
                        rank[set_q][w] <= '0;
                     else if (rank[set_q][w] < old_rank)
                        rank[set_q][w] <= rank[set_q][w] + WAY_W'(1);
                  end else if (demote) begin
                     if (WAY_W'(w) == tgt_q)
                        rank[set_q][w] <= LRU_RANK;
                     else if (rank[set_q][w] > old_rank)
                        rank[set_q][w] <= rank[set_q][w] - WAY_W'(1);
                  end
               end
               if (op_q == OP_MISS)  valid[set_q][tgt_q] <= 1'b1;
               if (op_q == OP_INVAL) valid[set_q][tgt_q] <= 1'b0;
               rsp_way   <= tgt_q;
               rsp_evict <= evict_q;
               rsp_err   <= err_q;
               rsp_valid <= 1'b1;
               state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l1_repl_ctrl.sv
// Directed bench for l1_repl_ctrl: victim selection, LRU update, INVAL, error
// flag, response back-pressure, mid-operation reset and rank permutation check.
module tb_l1_repl_ctrl;

   localparam int NUM_SETS = 16;
   localparam int WAYS     = 8;
   localparam int SET_W    = $clog2(NUM_SETS);
   localparam int WAY_W    = $clog2(WAYS);

   localparam logic [1:0] OP_HIT   = 2'b00;
   localparam logic [1:0] OP_MISS  = 2'b01;
   localparam logic [1:0] OP_INVAL = 2'b10;
   localparam logic [1:0] OP_NOP   = 2'b11;

   logic             clk;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [1:0]       req_op;
   logic [SET_W-1:0] req_set;
   logic [WAY_W-1:0] req_way;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WAY_W-1:0] rsp_way;
   logic             rsp_evict;
   logic             rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   l1_repl_ctrl #(.NUM_SETS(NUM_SETS), .WAYS(WAYS)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_set   (req_set),
      .req_way   (req_way),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_way   (rsp_way),
      .rsp_evict (rsp_evict),
      .rsp_err   (rsp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Every set's ranks must stay a permutation of 0..WAYS-1 on every cycle.
   always @(negedge clk) begin
      int ok;
      logic [WAYS-1:0] seen;
      ok = 1;
      for (int s = 0; s < NUM_SETS; s++) begin
         seen = '0;
         for (int w = 0; w < WAYS; w++) seen[dut.rank[s][w]] = 1'b1;
         if (seen != '1) ok = 0;
      end
      chk("rank_perm", ok, 1);
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_timeout", int'(req_ready), 1);
   endtask

   task automatic do_op(input logic [1:0] op, input int set, input int way, input int hold,
                        output int r_way, output int r_evict, output int r_err);
      int n;
      int first_way;
      @(negedge clk);
      wait_ready();
      req_valid = 1'b1;
      req_op    = op;
      req_set   = SET_W'(set);
      req_way   = WAY_W'(way);
      @(negedge clk);
      req_valid = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_timeout", int'(rsp_valid), 1);
      first_way = int'(rsp_way);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", int'(rsp_valid), 1);
         chk("hold_rsp_way", int'(rsp_way), first_way);
         chk("hold_req_ready", int'(req_ready), 0);
      end
      r_way   = int'(rsp_way);
      r_evict = int'(rsp_evict);
      r_err   = int'(rsp_err);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("post_rsp_valid", int'(rsp_valid), 0);
      chk("post_req_ready", int'(req_ready), 1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int w, e, r;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = OP_NOP;
      req_set   = '0;
      req_way   = '0;
      rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_way", int'(rsp_way), 0);
      chk("rst_rsp_evict", int'(rsp_evict), 0);
      chk("rst_rsp_err", int'(rsp_err), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", int'(req_ready), 1);

      // Fill set 3, then the first eviction hits the oldest fill.
      for (int i = 0; i < WAYS; i++) begin
         do_op(OP_MISS, 3, 0, 0, w, e, r);
         chk("t1_fill_way", w, i);
         chk("t1_fill_evict", e, 0);
      end
      do_op(OP_MISS, 3, 0, 0, w, e, r);
      chk("t1_evict_way", w, 0);
      chk("t1_evict_flag", e, 1);

      // Touching way 1 makes way 2 the LRU.
      do_op(OP_HIT, 3, 1, 0, w, e, r);
      chk("t2_hit_way", w, 1);
      chk("t2_hit_err", r, 0);
      chk("t2_hit_evict", e, 0);
      do_op(OP_MISS, 3, 0, 0, w, e, r);
      chk("t2_miss_way", w, 2);
      chk("t2_miss_evict", e, 1);

      do_op(OP_INVAL, 3, 5, 0, w, e, r);
      chk("t3_inval_way", w, 5);
      chk("t3_inval_evict", e, 0);
      chk("t3_inval_err", r, 0);
      do_op(OP_MISS, 3, 0, 0, w, e, r);
      chk("t3_miss_way", w, 5);
      chk("t3_miss_evict", e, 0);
      do_op(OP_MISS, 4, 0, 0, w, e, r);
      chk("t3_set4_way", w, 0);
      chk("t3_set4_evict", e, 0);

      // Back-pressure on the response.
      do_op(OP_NOP, 0, 6, 5, w, e, r);
      chk("t5_nop_way", w, 6);
      chk("t5_nop_evict", e, 0);
      chk("t5_nop_err", r, 0);

      do_reset();
      do_op(OP_HIT, 0, 2, 0, w, e, r);
      chk("t4_hit_err", r, 1);
      chk("t4_hit_way", w, 2);
      do_op(OP_MISS, 0, 0, 0, w, e, r);
      chk("t4_miss_way", w, 0);
      chk("t4_miss_evict", e, 0);
      chk("t4_miss_err", r, 0);

      // Reset while a MISS is in UPDATE drops it silently.
      do_op(OP_MISS, 5, 0, 0, w, e, r);
      chk("t6_pre0_way", w, 0);
      do_op(OP_MISS, 5, 0, 0, w, e, r);
      chk("t6_pre1_way", w, 1);
      @(negedge clk);
      wait_ready();
      req_valid = 1'b1;
      req_op    = OP_MISS;
      req_set   = SET_W'(5);
      req_way   = '0;
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      chk("t6_in_rst_valid", int'(rsp_valid), 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("t6_no_rsp", int'(rsp_valid), 0);
      end
      chk("t6_req_ready", int'(req_ready), 1);
      do_op(OP_MISS, 5, 0, 0, w, e, r);
      chk("t6_miss_way", w, 0);
      chk("t6_miss_evict", e, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got 1, expected 0");
      $fatal(1, "timeout");
   end

endmodule
